// File: rtl/unary_shift_multiplier.sv
// Serial unary multiplier: replays the a-register once per unit of b to emit a*b contiguous ones.
// Optional feature: UNARY_SHIFT_MULT_EARLY_TERM_EN ends the output frame right after the last 1 beat.
module unary_shift_multiplier #(
  parameter int BIN_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_a,
  input  logic in_b,
  input  logic in_valid,
  output logic out,
  output logic out_valid
);
  // state | meaning
  // IDLE  | waiting for the first beat of a frame
  // LOAD  | accumulating operand beats
  // EMIT  | streaming the unary product
  localparam int U_BITS    = 1 << BIN_BITS;
  localparam int OUT_BEATS = U_BITS * U_BITS;
  localparam int CW        = BIN_BITS + 1;

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t            state, state_nxt;
  logic [U_BITS-1:0] a_reg, a_nxt, work, work_nxt;
  logic [CW-1:0]     b_cnt, b_nxt, beat_cnt, beat_nxt;
  logic              out_nxt, out_valid_nxt;

  logic [U_BITS-1:0] a_load, a_src, w_src, w_shift, step_w;
  logic [CW-1:0]     b_load, b_src, step_b;
  logic              final_beat, one_avail;

`ifndef UNARY_SHIFT_MULT_EARLY_TERM_EN
  localparam logic [2*BIN_BITS-1:0] EMIT_LAST = {(2*BIN_BITS){1'b1}};
  logic [2*BIN_BITS-1:0] emit_cnt, emit_nxt;
`endif

  // The final load beat feeds the emit step directly, so the first EMIT cycle
  // already carries a valid output bit.
  always_comb begin
    a_load     = in_a ? {a_reg[U_BITS-2:0], 1'b1} : a_reg;
    b_load     = b_cnt + CW'(in_b);
    final_beat = in_valid && (beat_cnt == CW'(U_BITS - 1));
    if (state == EMIT) begin
      a_src = a_reg;
      b_src = b_cnt;
      w_src = work;
    end else begin
      a_src = a_load;
      b_src = b_load;
      w_src = a_load;
    end
    one_avail = (b_src != '0) && w_src[0];
    w_shift   = w_src >> 1;
    step_w    = w_src;
    step_b    = b_src;
    if (one_avail) begin
      if (w_shift == '0) begin
        step_w = a_src;
        step_b = b_src - CW'(1);
      end else begin
        step_w = w_shift;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a_reg;
    b_nxt         = b_cnt;
    beat_nxt      = beat_cnt;
    work_nxt      = work;
    out_nxt       = 1'b0;
    out_valid_nxt = 1'b0;
`ifndef UNARY_SHIFT_MULT_EARLY_TERM_EN
    emit_nxt      = emit_cnt;
`endif
    case (state)
      IDLE, LOAD: begin
        if (in_valid) begin
          a_nxt     = a_load;
          b_nxt     = b_load;
          beat_nxt  = beat_cnt + CW'(1);
          state_nxt = LOAD;
          if (final_beat) begin
            state_nxt     = EMIT;
            beat_nxt      = '0;
            work_nxt      = step_w;
            b_nxt         = step_b;
            out_nxt       = one_avail;
            out_valid_nxt = 1'b1;
`ifndef UNARY_SHIFT_MULT_EARLY_TERM_EN
            emit_nxt      = EMIT_LAST;
`endif
          end
        end
      end
      EMIT: begin
`ifdef UNARY_SHIFT_MULT_EARLY_TERM_EN
        if (one_avail) begin
          out_nxt       = 1'b1;
          out_valid_nxt = 1'b1;
          work_nxt      = step_w;
          b_nxt         = step_b;
        end else begin
          state_nxt = IDLE;
          a_nxt     = '0;
          b_nxt     = '0;
          work_nxt  = '0;
        end
`else
        if (emit_cnt != '0) begin
          out_nxt       = one_avail;
          out_valid_nxt = 1'b1;
          work_nxt      = step_w;
          b_nxt         = step_b;
          emit_nxt      = emit_cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
          a_nxt     = '0;
          b_nxt     = '0;
          work_nxt  = '0;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_cnt     <= '0;
      beat_cnt  <= '0;
      work      <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
`ifndef UNARY_SHIFT_MULT_EARLY_TERM_EN
      emit_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      a_reg     <= a_nxt;
      b_cnt     <= b_nxt;
      beat_cnt  <= beat_nxt;
      work      <= work_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
`ifndef UNARY_SHIFT_MULT_EARLY_TERM_EN
      emit_cnt  <= emit_nxt;
`endif
    end
  end

  // Keep the unused-parameter check quiet for widths derived only in one build.
  if (OUT_BEATS < U_BITS) begin : g_bad_param
    $error("OUT_BEATS must cover U_BITS");
  end
endmodule

// File: tb/tb_unary_shift_multiplier.sv
// Self-checking bench: directed vector table plus random frames scored by popcount product.
module tb_unary_shift_multiplier;
  logic clk = 1'b0;
  logic reset, in_a, in_b, in_valid;
  logic out, out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  unary_shift_multiplier #(.BIN_BITS(4)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b),
    .in_valid(in_valid), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a_bits;
    logic [15:0] b_bits;
    int          stall_at;
    int          stall_len;
    int          exp_ones;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_len(input int ones);
`ifdef UNARY_SHIFT_MULT_EARLY_TERM_EN
    return (ones > 0) ? ones : 1;
`else
    return 256;
`endif
  endfunction

  // Drives 16 accepted beats; returns at posedge+1 of the last accepted beat.
  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input int stall_at, input int stall_len);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          in_valid = 1'b0; in_a = 1'($urandom); in_b = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1; in_a = a[i]; in_b = b[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
  endtask

  // Observes the output frame; optionally throws junk beats at the DUT during EMIT.
  task automatic collect(input string name, input int exp_ones, input bit junk);
    int ones = 0, valid = 0, late = 0, cyc = 0;
    bit zero_seen = 1'b0;
    @(negedge clk);
    check({name, " emit_start"}, int'(out_valid), 1);
    while (out_valid === 1'b1 && cyc < 400) begin
      valid++;
      if (out === 1'b1) begin
        ones++;
        if (zero_seen) late++;
      end else begin
        zero_seen = 1'b1;
      end
      @(posedge clk); #1;
      if (junk) begin
        in_valid = 1'($urandom); in_a = 1'($urandom); in_b = 1'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0;
    check({name, " timeout"}, int'(cyc >= 400), 0);
    check({name, " ones"}, ones, exp_ones);
    check({name, " valid_len"}, valid, exp_len(exp_ones));
    check({name, " gap_ones"}, late, 0);
    check({name, " out_after"}, int'(out), 0);
  endtask

  initial begin
    vecs[0] = '{16'h0007, 16'h0003, -1, 0, 6};
    vecs[1] = '{16'h000F, 16'h7FFF, -1, 0, 60};
    vecs[2] = '{16'h7FFF, 16'h7FFF, -1, 0, 225};
    vecs[3] = '{16'h0007, 16'h0000, -1, 0, 0};
    vecs[4] = '{16'h0000, 16'h001F, -1, 0, 0};
    vecs[5] = '{16'h03FF, 16'h01FF, 8, 3, 90};

    reset = 1'b1; in_a = 1'b0; in_b = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset out", int'(out), 0);
    check("reset out_valid", int'(out_valid), 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].a_bits, vecs[i].b_bits, vecs[i].stall_at, vecs[i].stall_len);
      collect($sformatf("vec%0d", i), vecs[i].exp_ones, 1'b0);
    end

    // Reset in the middle of a long product frame.
    send_frame(16'h7FFF, 16'h7FFF, -1, 0);
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset out", int'(out), 0);
    check("midreset out_valid", int'(out_valid), 0);
    begin
      int stray = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (out_valid !== 1'b0 || out !== 1'b0) stray++;
      end
      check("midreset stray", stray, 0);
    end
    send_frame(16'h0003, 16'h0007, -1, 0);
    collect("post_reset", 6, 1'b0);

    // Random frames: non-thermometer operands, random stalls, junk during EMIT.
    for (int r = 0; r < 8; r++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (r == 0) a = 16'hFFFF;
      if (r == 0) b = 16'hFFFF;
      send_frame(a, b, int'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
      collect($sformatf("rand%0d", r), $countones(a) * $countones(b), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
